// File: rtl/id_ex_decode_stage_pkg.sv
// Shared RV32I decode constants and the ID/EX control bundle type.
package id_ex_decode_stage_pkg;

  localparam logic [6:0] OpcOp     = 7'b0110011;
  localparam logic [6:0] OpcOpImm  = 7'b0010011;
  localparam logic [6:0] OpcLoad   = 7'b0000011;
  localparam logic [6:0] OpcStore  = 7'b0100011;
  localparam logic [6:0] OpcBranch = 7'b1100011;
  localparam logic [6:0] OpcJal    = 7'b1101111;
  localparam logic [6:0] OpcJalr   = 7'b1100111;
  localparam logic [6:0] OpcLui    = 7'b0110111;
  localparam logic [6:0] OpcAuipc  = 7'b0010111;

  localparam logic [3:0] AluAdd  = 4'h0;
  localparam logic [3:0] AluSub  = 4'h1;
  localparam logic [3:0] AluXor  = 4'h2;
  localparam logic [3:0] AluOr   = 4'h3;
  localparam logic [3:0] AluAnd  = 4'h4;
  localparam logic [3:0] AluSll  = 4'h5;
  localparam logic [3:0] AluSrl  = 4'h6;
  localparam logic [3:0] AluSra  = 4'h7;
  localparam logic [3:0] AluSlt  = 4'h8;
  localparam logic [3:0] AluSltu = 4'h9;
  localparam logic [3:0] AluEq   = 4'hA;
  localparam logic [3:0] AluNe   = 4'hB;
  localparam logic [3:0] AluLt   = 4'hC;
  localparam logic [3:0] AluGe   = 4'hD;
  localparam logic [3:0] AluLtu  = 4'hE;
  localparam logic [3:0] AluGeu  = 4'hF;

  localparam logic [1:0] WbAlu = 2'b00;
  localparam logic [1:0] WbMem = 2'b01;
  localparam logic [1:0] WbPc4 = 2'b10;
  localparam logic [1:0] WbImm = 2'b11;

  localparam logic [1:0] JmpNone = 2'b00;
  localparam logic [1:0] JmpJal  = 2'b01;
  localparam logic [1:0] JmpJalr = 2'b10;

  localparam logic [0:0] StRun   = 1'b0;
  localparam logic [0:0] StStall = 1'b1;

  typedef struct packed {
    logic       alu_src;
    logic       branch;
    logic [1:0] jump;
    logic       mem_ren;
    logic       mem_wen;
    logic [2:0] mem_size;
    logic [1:0] wb_sel;
    logic       reg_wen;
    logic       illegal;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
  } ctrl_t;

endpackage

// File: rtl/rv32_decode_comb.sv
// Pure combinational RV32I decoder: instruction -> control bundle, immediate, mnemonic.
module rv32_decode_comb
  import id_ex_decode_stage_pkg::*;
#(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned ALU_CTRL_W = 4,
  parameter int unsigned DBG_STR    = 1
) (
  input  logic [31:0]           instr,
  output ctrl_t                 ctrl,
  output logic [ALU_CTRL_W-1:0] alu_ctrl,
  output logic [XLEN-1:0]       imm,
  output logic                  rs1_used,
  output logic                  rs2_used,
  output logic [79:0]           decode_str
);

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [4:0]  rd_f;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];
  assign rd_f   = instr[11:7];

  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {instr[31:12], 12'b0};
  assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  ctrl_t       dec;
  logic [3:0]  alu4;
  logic [31:0] imm32;
  logic        use1, use2, has_rd, legal;
  logic [79:0] str;

  always_comb begin
    dec    = '0;
    alu4   = AluAdd;
    imm32  = '0;
    use1   = 1'b0;
    use2   = 1'b0;
    has_rd = 1'b0;
    legal  = 1'b1;
    str    = '0;
    case (opcode)
      OpcOp: begin
        use1 = 1'b1;
        use2 = 1'b1;
        has_rd = 1'b1;
        dec.wb_sel = WbAlu;
        // Only funct7[5] may be set, and only for SUB/SRA.
        if ((funct7 & 7'b1011111) != 7'd0) legal = 1'b0;
        case ({funct7[5], funct3})
          4'b0_000: begin alu4 = AluAdd;  str = 80'("ADD");  end
          4'b1_000: begin alu4 = AluSub;  str = 80'("SUB");  end
          4'b0_001: begin alu4 = AluSll;  str = 80'("SLL");  end
          4'b0_010: begin alu4 = AluSlt;  str = 80'("SLT");  end
          4'b0_011: begin alu4 = AluSltu; str = 80'("SLTU"); end
          4'b0_100: begin alu4 = AluXor;  str = 80'("XOR");  end
          4'b0_101: begin alu4 = AluSrl;  str = 80'("SRL");  end
          4'b1_101: begin alu4 = AluSra;  str = 80'("SRA");  end
          4'b0_110: begin alu4 = AluOr;   str = 80'("OR");   end
          4'b0_111: begin alu4 = AluAnd;  str = 80'("AND");  end
          default:  legal = 1'b0;
        endcase
      end
      OpcOpImm: begin
        use1 = 1'b1;
        has_rd = 1'b1;
        dec.alu_src = 1'b1;
        imm32 = imm_i;
        case (funct3)
          3'b000: begin alu4 = AluAdd;  str = 80'("ADDI");  end
          3'b010: begin alu4 = AluSlt;  str = 80'("SLTI");  end
          3'b011: begin alu4 = AluSltu; str = 80'("SLTIU"); end
          3'b100: begin alu4 = AluXor;  str = 80'("XORI");  end
          3'b110: begin alu4 = AluOr;   str = 80'("ORI");   end
          3'b111: begin alu4 = AluAnd;  str = 80'("ANDI");  end
          3'b001: begin
            alu4 = AluSll;
            str = 80'("SLLI");
            if (funct7 != 7'b0000000) legal = 1'b0;
          end
          default: begin
            if (funct7 == 7'b0000000) begin
              alu4 = AluSrl;
              str = 80'("SRLI");
            end else if (funct7 == 7'b0100000) begin
              alu4 = AluSra;
              str = 80'("SRAI");
            end else begin
              legal = 1'b0;
            end
          end
        endcase
      end
      OpcLoad: begin
        use1 = 1'b1;
        has_rd = 1'b1;
        dec.alu_src = 1'b1;
        dec.mem_ren = 1'b1;
        dec.mem_size = funct3;
        dec.wb_sel = WbMem;
        imm32 = imm_i;
        case (funct3)
          3'b000:  str = 80'("LB");
          3'b001:  str = 80'("LH");
          3'b010:  str = 80'("LW");
          3'b100:  str = 80'("LBU");
          3'b101:  str = 80'("LHU");
          default: legal = 1'b0;
        endcase
      end
      OpcStore: begin
        use1 = 1'b1;
        use2 = 1'b1;
        dec.alu_src = 1'b1;
        dec.mem_wen = 1'b1;
        dec.mem_size = funct3;
        imm32 = imm_s;
        case (funct3)
          3'b000:  str = 80'("SB");
          3'b001:  str = 80'("SH");
          3'b010:  str = 80'("SW");
          default: legal = 1'b0;
        endcase
      end
      OpcBranch: begin
        use1 = 1'b1;
        use2 = 1'b1;
        dec.branch = 1'b1;
        imm32 = imm_b;
        case (funct3)
          3'b000:  begin alu4 = AluEq;  str = 80'("BEQ");  end
          3'b001:  begin alu4 = AluNe;  str = 80'("BNE");  end
          3'b100:  begin alu4 = AluLt;  str = 80'("BLT");  end
          3'b101:  begin alu4 = AluGe;  str = 80'("BGE");  end
          3'b110:  begin alu4 = AluLtu; str = 80'("BLTU"); end
          3'b111:  begin alu4 = AluGeu; str = 80'("BGEU"); end
          default: legal = 1'b0;
        endcase
      end
      OpcJal: begin
        has_rd = 1'b1;
        dec.jump = JmpJal;
        dec.wb_sel = WbPc4;
        imm32 = imm_j;
        str = 80'("JAL");
      end
      OpcJalr: begin
        use1 = 1'b1;
        has_rd = 1'b1;
        dec.alu_src = 1'b1;
        dec.jump = JmpJalr;
        dec.wb_sel = WbPc4;
        imm32 = imm_i;
        str = 80'("JALR");
        if (funct3 != 3'b000) legal = 1'b0;
      end
      OpcLui: begin
        has_rd = 1'b1;
        dec.alu_src = 1'b1;
        dec.wb_sel = WbImm;
        imm32 = imm_u;
        str = 80'("LUI");
      end
      OpcAuipc: begin
        has_rd = 1'b1;
        dec.alu_src = 1'b1;
        dec.wb_sel = WbAlu;
        imm32 = imm_u;
        str = 80'("AUIPC");
      end
      default: legal = 1'b0;
    endcase

    // Illegal encodings collapse to a bubble-shaped bundle carrying only the flag.
    if (!legal) begin
      dec         = '0;
      dec.illegal = 1'b1;
      alu4        = AluAdd;
      imm32       = '0;
      use1        = 1'b0;
      use2        = 1'b0;
      has_rd      = 1'b0;
      str         = 80'("ILLEGAL");
    end

    dec.reg_wen = has_rd & (rd_f != 5'd0);
    dec.rs1     = use1 ? instr[19:15] : 5'd0;
    dec.rs2     = use2 ? instr[24:20] : 5'd0;
    dec.rd      = has_rd ? rd_f : 5'd0;
  end

  assign ctrl       = dec;
  assign alu_ctrl   = ALU_CTRL_W'(alu4);
  assign imm        = XLEN'($signed(imm32));
  assign rs1_used   = use1;
  assign rs2_used   = use2;
  assign decode_str = (DBG_STR != 0) ? str : 80'd0;

endmodule

// File: rtl/id_ex_decode_stage.sv
// RV32I decode stage: ID/EX register, load-use hazard detection and flush/stall control.
module id_ex_decode_stage
  import id_ex_decode_stage_pkg::*;
#(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned ALU_CTRL_W = 4,
  parameter int unsigned DBG_STR    = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  id_valid,
  input  logic [31:0]           id_instr,
  input  logic                  ex_flush,
  input  logic                  ex_stall,
  output logic                  id_stall,
  output logic                  ex_valid,
  output logic [ALU_CTRL_W-1:0] ex_alu_ctrl,
  output logic                  ex_alu_src,
  output logic                  ex_branch,
  output logic [1:0]            ex_jump,
  output logic                  ex_mem_ren,
  output logic                  ex_mem_wen,
  output logic [2:0]            ex_mem_size,
  output logic [1:0]            ex_wb_sel,
  output logic                  ex_reg_wen,
  output logic [4:0]            ex_rs1,
  output logic [4:0]            ex_rs2,
  output logic [4:0]            ex_rd,
  output logic [XLEN-1:0]       ex_imm,
  output logic                  ex_illegal,
  output logic [79:0]           ex_decode_str
);

  localparam logic [79:0] StrReset  = (DBG_STR != 0) ? 80'("RESET") : 80'd0;
  localparam logic [79:0] StrBubble = (DBG_STR != 0) ? 80'("BUBBLE") : 80'd0;

  ctrl_t                 dec_ctrl;
  logic [ALU_CTRL_W-1:0] dec_alu;
  logic [XLEN-1:0]       dec_imm;
  logic                  dec_rs1_used, dec_rs2_used;
  logic [79:0]           dec_str;

  rv32_decode_comb #(
    .XLEN      (XLEN),
    .ALU_CTRL_W(ALU_CTRL_W),
    .DBG_STR   (DBG_STR)
  ) u_decode (
    .instr     (id_instr),
    .ctrl      (dec_ctrl),
    .alu_ctrl  (dec_alu),
    .imm       (dec_imm),
    .rs1_used  (dec_rs1_used),
    .rs2_used  (dec_rs2_used),
    .decode_str(dec_str)
  );

  ctrl_t                 ctrl_q, ctrl_d;
  logic [ALU_CTRL_W-1:0] alu_q, alu_d;
  logic [XLEN-1:0]       imm_q, imm_d;
  logic                  valid_q, valid_d;
  logic [79:0]           str_q, str_d;
  logic [0:0]            state_q, state_d;
  logic                  hazard;

  // Unused source fields are zeroed by the decoder, but the used flags keep this explicit.
  assign hazard = id_valid & valid_q & ctrl_q.mem_ren & (ctrl_q.rd != 5'd0) &
                  ((dec_rs1_used & (dec_ctrl.rs1 == ctrl_q.rd)) |
                   (dec_rs2_used & (dec_ctrl.rs2 == ctrl_q.rd)));

  // A single bubble per load-use pair: no new stall request from the STALL state.
  assign id_stall = hazard & ~ex_flush & (state_q == StRun);

  always_comb begin
    logic load_bubble;
    logic load_dec;
    ctrl_d      = ctrl_q;
    alu_d       = alu_q;
    imm_d       = imm_q;
    valid_d     = valid_q;
    str_d       = str_q;
    state_d     = state_q;
    load_bubble = 1'b0;
    load_dec    = 1'b0;
    if (ex_flush) begin
      load_bubble = 1'b1;
      state_d     = StRun;
    end else if (!ex_stall) begin
      if (id_stall) begin
        load_bubble = 1'b1;
        state_d     = StStall;
      end else begin
        state_d     = StRun;
        load_dec    = id_valid;
        load_bubble = ~id_valid;
      end
    end
    if (load_bubble) begin
      ctrl_d  = '0;
      alu_d   = '0;
      imm_d   = '0;
      valid_d = 1'b0;
      str_d   = StrBubble;
    end
    if (load_dec) begin
      ctrl_d  = dec_ctrl;
      alu_d   = dec_alu;
      imm_d   = dec_imm;
      valid_d = 1'b1;
      str_d   = dec_str;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl_q  <= '0;
      alu_q   <= '0;
      imm_q   <= '0;
      valid_q <= 1'b0;
      str_q   <= StrReset;
      state_q <= StRun;
    end else begin
      ctrl_q  <= ctrl_d;
      alu_q   <= alu_d;
      imm_q   <= imm_d;
      valid_q <= valid_d;
      str_q   <= str_d;
      state_q <= state_d;
    end
  end

  assign ex_valid      = valid_q;
  assign ex_alu_ctrl   = alu_q;
  assign ex_alu_src    = ctrl_q.alu_src;
  assign ex_branch     = ctrl_q.branch;
  assign ex_jump       = ctrl_q.jump;
  assign ex_mem_ren    = ctrl_q.mem_ren;
  assign ex_mem_wen    = ctrl_q.mem_wen;
  assign ex_mem_size   = ctrl_q.mem_size;
  assign ex_wb_sel     = ctrl_q.wb_sel;
  assign ex_reg_wen    = ctrl_q.reg_wen;
  assign ex_rs1        = ctrl_q.rs1;
  assign ex_rs2        = ctrl_q.rs2;
  assign ex_rd         = ctrl_q.rd;
  assign ex_imm        = imm_q;
  assign ex_illegal    = ctrl_q.illegal;
  assign ex_decode_str = str_q;

endmodule

// File: tb/tb_id_ex_decode_stage.sv
// Scoreboard bench for id_ex_decode_stage: directed RV32I vectors with hand-computed bundles.
module tb_id_ex_decode_stage;

  typedef struct packed {
    logic [3:0]  alu;
    logic        alu_src;
    logic        branch;
    logic [1:0]  jump;
    logic        mem_ren;
    logic        mem_wen;
    logic [2:0]  mem_size;
    logic [1:0]  wb_sel;
    logic        reg_wen;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic        illegal;
    logic [79:0] str;
  } exp_t;

  logic        clk, reset_n, id_valid, ex_flush, ex_stall;
  logic [31:0] id_instr;
  logic        id_stall, ex_valid, ex_alu_src, ex_branch, ex_mem_ren, ex_mem_wen;
  logic        ex_reg_wen, ex_illegal;
  logic [3:0]  ex_alu_ctrl;
  logic [1:0]  ex_jump, ex_wb_sel;
  logic [2:0]  ex_mem_size;
  logic [4:0]  ex_rs1, ex_rs2, ex_rd;
  logic [31:0] ex_imm;
  logic [79:0] ex_decode_str;

  id_ex_decode_stage dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .id_valid     (id_valid),
    .id_instr     (id_instr),
    .ex_flush     (ex_flush),
    .ex_stall     (ex_stall),
    .id_stall     (id_stall),
    .ex_valid     (ex_valid),
    .ex_alu_ctrl  (ex_alu_ctrl),
    .ex_alu_src   (ex_alu_src),
    .ex_branch    (ex_branch),
    .ex_jump      (ex_jump),
    .ex_mem_ren   (ex_mem_ren),
    .ex_mem_wen   (ex_mem_wen),
    .ex_mem_size  (ex_mem_size),
    .ex_wb_sel    (ex_wb_sel),
    .ex_reg_wen   (ex_reg_wen),
    .ex_rs1       (ex_rs1),
    .ex_rs2       (ex_rs2),
    .ex_rd        (ex_rd),
    .ex_imm       (ex_imm),
    .ex_illegal   (ex_illegal),
    .ex_decode_str(ex_decode_str)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int    n_tests = 0;
  int    n_fail  = 0;
  exp_t  exp_q[$];
  string name_q[$];
  logic  held = 1'b0;
  exp_t  mon_got, mon_exp;
  string mon_name;

  function automatic exp_t mk(int alu, int src, int br, int jmp, int ren, int wen, int size,
                              int wb, int rwen, int rs1, int rs2, int rd, logic [31:0] imm,
                              int ill, logic [79:0] str);
    exp_t e;
    e.alu = 4'(alu);       e.alu_src = 1'(src);   e.branch = 1'(br);
    e.jump = 2'(jmp);      e.mem_ren = 1'(ren);   e.mem_wen = 1'(wen);
    e.mem_size = 3'(size); e.wb_sel = 2'(wb);     e.reg_wen = 1'(rwen);
    e.rs1 = 5'(rs1);       e.rs2 = 5'(rs2);       e.rd = 5'(rd);
    e.imm = imm;           e.illegal = 1'(ill);   e.str = str;
    return e;
  endfunction

  function automatic exp_t sample();
    exp_t s;
    s.alu = ex_alu_ctrl;   s.alu_src = ex_alu_src; s.branch = ex_branch;
    s.jump = ex_jump;      s.mem_ren = ex_mem_ren; s.mem_wen = ex_mem_wen;
    s.mem_size = ex_mem_size; s.wb_sel = ex_wb_sel; s.reg_wen = ex_reg_wen;
    s.rs1 = ex_rs1;        s.rs2 = ex_rs2;         s.rd = ex_rd;
    s.imm = ex_imm;        s.illegal = ex_illegal; s.str = ex_decode_str;
    return s;
  endfunction

  // A held ID/EX register re-presents the same bundle; only fresh loads are scored.
  always @(posedge clk) held <= reset_n && ex_stall && !ex_flush;

  always @(negedge clk) begin
    if (reset_n && ex_valid && !held) begin
      mon_got = sample();
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_issue got=%h want=<none>", mon_got);
      end else begin
        mon_exp  = exp_q.pop_front();
        mon_name = name_q.pop_front();
        if (mon_got !== mon_exp) begin
          n_fail++;
          $display("FAIL issue_%s got=%h want=%h", mon_name, mon_got, mon_exp);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic issue(input string name, input logic [31:0] ins, input exp_t e);
    id_valid = 1'b1;
    id_instr = ins;
    exp_q.push_back(e);
    name_q.push_back(name);
    step();
  endtask

  localparam logic [31:0] IAdd3 = 32'h002081B3;
  localparam logic [31:0] ILw5  = 32'h0000A283;
  localparam logic [31:0] IAdd6 = 32'h00528333;

  initial begin
    logic [79:0] s_reset, s_bubble;
    exp_t e_add3, e_lw5, e_add6, e_ill;
    s_reset  = 80'("RESET");
    s_bubble = 80'("BUBBLE");
    e_add3 = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 2, 3, 32'h0, 0, 80'("ADD"));
    e_lw5  = mk(0, 1, 0, 0, 1, 0, 2, 1, 1, 1, 0, 5, 32'h0, 0, 80'("LW"));
    e_add6 = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 5, 5, 6, 32'h0, 0, 80'("ADD"));
    e_ill  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 1, 80'("ILLEGAL"));

    reset_n = 1'b1; id_valid = 1'b0; id_instr = '0; ex_flush = 1'b0; ex_stall = 1'b0;
    #1 reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    chk("reset_bundle", {ex_valid, ex_alu_ctrl, ex_alu_src, ex_branch, ex_jump, ex_mem_ren,
        ex_mem_wen, ex_mem_size, ex_wb_sel, ex_reg_wen, ex_rs1, ex_rs2, ex_rd, ex_imm,
        ex_illegal}, '0);
    chk("reset_str", ex_decode_str, s_reset);
    chk("reset_id_stall", id_stall, 0);
    reset_n = 1'b1;
    step();
    chk("post_reset_empty", ex_valid, 0);
    chk("post_reset_bubble_str", ex_decode_str, s_bubble);

    issue("add", IAdd3, e_add3);
    issue("sub", 32'h402083B3, mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 2, 7, 32'h0, 0, 80'("SUB")));
    issue("srai", 32'h4030D213,
          mk(7, 1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 4, 32'h403, 0, 80'("SRAI")));
    issue("addi_x0", 32'h00100013,
          mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h1, 0, 80'("ADDI")));
    issue("beq", 32'h00208463, mk(10, 0, 1, 0, 0, 0, 0, 0, 0, 1, 2, 0, 32'h8, 0, 80'("BEQ")));
    issue("jal", 32'hFFDFF0EF,
          mk(0, 0, 0, 1, 0, 0, 0, 2, 1, 0, 0, 1, 32'hFFFFFFFC, 0, 80'("JAL")));
    issue("sw", 32'h0020A223, mk(0, 1, 0, 0, 0, 1, 2, 0, 0, 1, 2, 0, 32'h4, 0, 80'("SW")));
    issue("lui", 32'h123452B7,
          mk(0, 1, 0, 0, 0, 0, 0, 3, 1, 0, 0, 5, 32'h12345000, 0, 80'("LUI")));
    issue("illegal_ones", 32'hFFFFFFFF, e_ill);
    issue("illegal_ld", 32'h0000B283, e_ill);

    // Plain load-use: one stall cycle, one bubble, then the consumer.
    issue("lw_a", ILw5, e_lw5);
    id_instr = IAdd6;
    #1 chk("load_use_stall", id_stall, 1);
    step();
    chk("load_use_bubble", ex_valid, 0);
    chk("load_use_bubble_str", ex_decode_str, s_bubble);
    chk("stall_one_cycle", id_stall, 0);
    issue("add_after_lw_a", IAdd6, e_add6);

    // Downstream hold keeps the load in ID/EX and the hazard visible.
    issue("lw_b", ILw5, e_lw5);
    ex_stall = 1'b1;
    id_instr = IAdd6;
    #1 chk("stall_vs_held", id_stall, 1);
    step();
    chk("hold_keeps_load", {ex_valid, ex_mem_ren, ex_rd}, {1'b1, 1'b1, 5'd5});
    chk("hold_still_stalls", id_stall, 1);
    ex_stall = 1'b0;
    step();
    chk("hold_then_bubble", ex_valid, 0);
    issue("add_after_lw_b", IAdd6, e_add6);

    // Flush overrides both the downstream hold and a pending load-use.
    issue("lw_c", ILw5, e_lw5);
    ex_stall = 1'b1;
    ex_flush = 1'b1;
    id_instr = IAdd6;
    #1 chk("flush_kills_stall", id_stall, 0);
    step();
    chk("flush_bubble", ex_valid, 0);
    ex_stall = 1'b0;
    ex_flush = 1'b0;
    #1 chk("after_flush_no_stall", id_stall, 0);
    issue("add_after_flush", IAdd6, e_add6);

    id_valid = 1'b0;
    id_instr = 32'hFFFFFFFF;
    step();
    chk("invalid_no_issue", {ex_valid, ex_illegal}, 0);

    // Asynchronous reset while the stage sits in STALL.
    issue("lw_d", ILw5, e_lw5);
    id_instr = IAdd6;
    step();
    #1 reset_n = 1'b0;
    #1;
    chk("async_reset_bundle", {ex_valid, ex_mem_ren, ex_rd, ex_reg_wen}, 0);
    chk("async_reset_str", ex_decode_str, s_reset);
    chk("async_reset_id_stall", id_stall, 0);
    repeat (2) @(posedge clk);
    #2 reset_n = 1'b1;
    issue("add_after_reset", IAdd3, e_add3);
    chk("restart_no_stall", id_stall, 0);

    id_valid = 1'b0;
    repeat (3) step();
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout got=running want=finished");
    $fatal(1, "timeout");
  end

endmodule
